// File: rtl/screen_tx_arbiter.sv
// Two-channel round-robin UART frame arbiter: streams the granted channel's
// payload, appends a Modbus CRC-16 (low byte first), then holds an idle gap.
module screen_tx_arbiter #(
  parameter int GAP_CYC = 365000,
  parameter int TO_CYC  = 200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic [7:0] len0,
  input  logic [7:0] rd_data0,
  input  logic       req1,
  input  logic [7:0] len1,
  input  logic [7:0] rd_data1,
  output logic [7:0] rd_addr,
  output logic [1:0] gnt,
  output logic [1:0] done,
  output logic       err,
  output logic       busy,
  output logic [7:0] data_tx,
  output logic       data_tx_flash,
  input  logic       tx_finish
);

  localparam int MAX_CYC = (GAP_CYC > TO_CYC) ? GAP_CYC : TO_CYC;
  localparam int TW      = $clog2(MAX_CYC + 1);
  localparam logic [TW-1:0] GAP_LAST = TW'(GAP_CYC - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TO_CYC - 1);
  localparam logic [TW-1:0] TMR_ONE  = TW'(1);

  typedef enum logic [2:0] {
    IDLE, GRANT, FETCH, SEND, WAIT_FIN, CRC_LO, CRC_HI, GAP
  } state_t;

  // Which byte the UART is currently shifting, so WAIT_FIN knows where to go next.
  typedef enum logic [1:0] {
    K_DATA, K_CRC_LO, K_CRC_HI
  } kind_t;

  state_t        state_q, state_d;
  kind_t         kind_q, kind_d;
  logic          ptr_q, ptr_d;
  logic          ch_q, ch_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    rd_addr_q, rd_addr_d;
  logic [7:0]    data_tx_q, data_tx_d;
  logic [15:0]   crc_q, crc_d;
  logic [1:0]    gnt_q, gnt_d;
  logic [TW-1:0] tmr_q, tmr_d;

  logic [1:0] done_d;
  logic       err_d;
  logic       flash_d;
  logic       win;
  logic [1:0] ch_onehot;
  logic [7:0] len_sel;
  logic [7:0] rd_sel;

  function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in,
                                             input logic [7:0]  data);
    logic [15:0] c;
    c = crc_in ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  always_comb begin
    win = 1'b0;
    if (req0 && req1) begin
      win = ~ptr_q;
    end else if (req1) begin
      win = 1'b1;
    end
  end

  assign ch_onehot = ch_q ? 2'b10 : 2'b01;
  assign len_sel   = ch_q ? len1 : len0;
  assign rd_sel    = ch_q ? rd_data1 : rd_data0;

  // The timer defaults to zero so every state change restarts it.
  always_comb begin
    state_d   = state_q;
    kind_d    = kind_q;
    ptr_d     = ptr_q;
    ch_d      = ch_q;
    len_d     = len_q;
    rd_addr_d = rd_addr_q;
    data_tx_d = data_tx_q;
    crc_d     = crc_q;
    gnt_d     = gnt_q;
    tmr_d     = '0;
    done_d    = 2'b00;
    err_d     = 1'b0;
    flash_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          ch_d    = win;
          ptr_d   = win;
          gnt_d   = win ? 2'b10 : 2'b01;
          state_d = GRANT;
        end
      end

      GRANT: begin
        len_d     = len_sel;
        rd_addr_d = 8'd0;
        crc_d     = 16'hFFFF;
        if (len_sel == 8'd0) begin
          done_d  = ch_onehot;
          gnt_d   = 2'b00;
          state_d = GAP;
        end else begin
          state_d = FETCH;
        end
      end

      // First cycle lets the buffer register the address; second captures its data.
      FETCH: begin
        if (tmr_q == '0) begin
          tmr_d = tmr_q + TMR_ONE;
        end else begin
          data_tx_d = rd_sel;
          state_d   = SEND;
        end
      end

      SEND: begin
        flash_d = 1'b1;
        crc_d   = crc16_byte(crc_q, data_tx_q);
        kind_d  = K_DATA;
        state_d = WAIT_FIN;
      end

      CRC_LO: begin
        flash_d = 1'b1;
        kind_d  = K_CRC_LO;
        state_d = WAIT_FIN;
      end

      CRC_HI: begin
        flash_d = 1'b1;
        kind_d  = K_CRC_HI;
        state_d = WAIT_FIN;
      end

      // tx_finish is checked before the timeout so a coincident finish wins.
      WAIT_FIN: begin
        if (tx_finish) begin
          case (kind_q)
            K_DATA: begin
              if (rd_addr_q == len_q - 8'd1) begin
                data_tx_d = crc_q[7:0];
                state_d   = CRC_LO;
              end else begin
                rd_addr_d = rd_addr_q + 8'd1;
                state_d   = FETCH;
              end
            end
            K_CRC_LO: begin
              data_tx_d = crc_q[15:8];
              state_d   = CRC_HI;
            end
            default: begin
              done_d  = ch_onehot;
              gnt_d   = 2'b00;
              state_d = GAP;
            end
          endcase
        end else if (tmr_q == TO_LAST) begin
          err_d   = 1'b1;
          done_d  = ch_onehot;
          gnt_d   = 2'b00;
          state_d = GAP;
        end else begin
          tmr_d = tmr_q + TMR_ONE;
        end
      end

      GAP: begin
        if (tmr_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          tmr_d = tmr_q + TMR_ONE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      kind_q    <= K_DATA;
      ptr_q     <= 1'b1;
      ch_q      <= 1'b0;
      len_q     <= 8'd0;
      rd_addr_q <= 8'd0;
      data_tx_q <= 8'd0;
      crc_q     <= 16'hFFFF;
      gnt_q     <= 2'b00;
      tmr_q     <= '0;
    end else begin
      state_q   <= state_d;
      kind_q    <= kind_d;
      ptr_q     <= ptr_d;
      ch_q      <= ch_d;
      len_q     <= len_d;
      rd_addr_q <= rd_addr_d;
      data_tx_q <= data_tx_d;
      crc_q     <= crc_d;
      gnt_q     <= gnt_d;
      tmr_q     <= tmr_d;
    end
  end

  assign rd_addr       = rd_addr_q;
  assign gnt           = gnt_q;
  assign done          = done_d;
  assign err           = err_d;
  assign busy          = (state_q != IDLE);
  assign data_tx       = data_tx_q;
  assign data_tx_flash = flash_d;

endmodule

// File: tb/tb_screen_tx_arbiter.sv
// Directed bench for screen_tx_arbiter: a latency-100 UART model, registered
// payload buffers and a byte scoreboard filled when each frame is set up.
module tb_screen_tx_arbiter;

  localparam int GAP      = 50;
  localparam int TO       = 200;
  localparam int UART_LAT = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [7:0] len0 = 8'd0, len1 = 8'd0;
  logic [7:0] rd_data0 = 8'd0, rd_data1 = 8'd0;
  logic [7:0] rd_addr;
  logic [1:0] gnt, done;
  logic       err, busy, data_tx_flash;
  logic [7:0] data_tx;
  logic       tx_finish;
  logic       uart_fin = 1'b0;
  logic       stray_fin = 1'b0;

  logic [7:0] mem0 [256];
  logic [7:0] mem1 [256];
  logic [7:0] payload [$];
  logic [7:0] exp_q [$];
  logic [1:0] gnt_log [$];
  logic [1:0] gnt_prev = 2'b00;

  int pass_cnt = 0, total_cnt = 0, fail_cnt = 0;
  int n_flash = 0, n_done0 = 0, n_done1 = 0, n_err = 0;
  int uart_cnt = 0, uart_n = 0, uart_drop = 0;
  int rd_addr_max = 0;

  always #5 clk = ~clk;

  assign tx_finish = uart_fin | stray_fin;

  screen_tx_arbiter #(.GAP_CYC(GAP), .TO_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .len0(len0), .rd_data0(rd_data0),
    .req1(req1), .len1(len1), .rd_data1(rd_data1),
    .rd_addr(rd_addr), .gnt(gnt), .done(done), .err(err), .busy(busy),
    .data_tx(data_tx), .data_tx_flash(data_tx_flash), .tx_finish(tx_finish)
  );

  always @(posedge clk) begin
    rd_data0 <= mem0[rd_addr];
    rd_data1 <= mem1[rd_addr];
  end

  // UART: finish pulse UART_LAT cycles after each load, optionally dropped for one byte.
  always @(posedge clk) begin
    #1;
    uart_fin = 1'b0;
    if (uart_cnt != 0) begin
      uart_cnt = uart_cnt - 1;
      if (uart_cnt == 0) uart_fin = 1'b1;
    end
    if (rst && data_tx_flash) begin
      uart_n = uart_n + 1;
      if (uart_n != uart_drop) uart_cnt = UART_LAT;
    end
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (data_tx_flash) begin
        n_flash++;
        total_cnt++;
        assert (exp_q.size() > 0) begin
          pass_cnt++;
        end else begin
          fail_cnt++;
          $error("[TB] FAIL sb_extra_flash: observed byte %0h expected no flash", data_tx);
        end
        if (exp_q.size() > 0) check_output("sb_byte", 32'(data_tx), 32'(exp_q.pop_front()));
      end
      if (done[0]) n_done0++;
      if (done[1]) n_done1++;
      if (err) n_err++;
      if (gnt != 2'b00 && gnt_prev == 2'b00) gnt_log.push_back(gnt);
      if (int'(rd_addr) > rd_addr_max) rd_addr_max = int'(rd_addr);
    end
    gnt_prev = gnt;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [15:0] crc_step(input logic [15:0] c_in, input logic [7:0] b);
    logic [15:0] c;
    c = c_in ^ {8'h00, b};
    for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    return c;
  endfunction

  // Writes payload into the channel buffer and queues the first n_exp wire bytes.
  task automatic load_frame(input int ch, input int n_exp);
    logic [15:0] c;
    logic [7:0]  fr [$];
    c = 16'hFFFF;
    for (int i = 0; i < payload.size(); i++) begin
      if (ch == 0) mem0[i] = payload[i];
      else         mem1[i] = payload[i];
      c = crc_step(c, payload[i]);
      fr.push_back(payload[i]);
    end
    fr.push_back(c[7:0]);
    fr.push_back(c[15:8]);
    if (ch == 0) len0 = 8'(payload.size());
    else         len1 = 8'(payload.size());
    for (int i = 0; i < n_exp; i++) exp_q.push_back(fr[i]);
  endtask

  task automatic wait_done(input int ch, input int budget, input string tag);
    int base;
    int k;
    base = (ch == 0) ? n_done0 : n_done1;
    k = 0;
    while (((ch == 0) ? n_done0 : n_done1) == base && k < budget) begin
      tick();
      k++;
    end
    check_output(tag, 32'(((ch == 0) ? n_done0 : n_done1) - base), 32'd1);
  endtask

  task automatic wait_flashes(input int target, input int budget, input string tag);
    int k;
    k = 0;
    while (n_flash < target && k < budget) begin
      tick();
      k++;
    end
    check_output(tag, 32'(n_flash), 32'(target));
  endtask

  task automatic measure_busy(output int n, output logic [1:0] g);
    n = 0;
    g = 2'b00;
    tick();
    while (busy && n < 4 * GAP) begin
      g = g | gnt;
      n++;
      tick();
    end
  endtask

  initial begin
    int fl, d0, d1, e, n, k;
    logic [1:0] g;

    $display("[TB] reset state");
    for (int i = 0; i < 256; i++) begin mem0[i] = 8'h00; mem1[i] = 8'h00; end
    tick(); tick();
    check_output("rst_gnt", 32'(gnt), 32'd0);
    check_output("rst_done", 32'(done), 32'd0);
    check_output("rst_err", 32'(err), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_flash", 32'(data_tx_flash), 32'd0);
    check_output("rst_data_tx", 32'(data_tx), 32'd0);
    check_output("rst_rd_addr", 32'(rd_addr), 32'd0);

    $display("[TB] V1 ch0 len 6 Modbus frame");
    payload = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01};
    load_frame(0, 0);
    exp_q = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h84, 8'h0A};
    fl = n_flash;
    rst = 1'b1;
    req0 = 1'b1;
    tick();
    check_output("v1_gnt_first_cycle", 32'(gnt), 32'h1);
    check_output("v1_busy", 32'(busy), 32'd1);
    req0 = 1'b0;
    wait_done(0, 2000, "v1_done");
    check_output("v1_gnt_held", 32'(gnt), 32'h1);
    check_output("v1_flashes", 32'(n_flash - fl), 32'd8);
    check_output("v1_sb_empty", 32'(exp_q.size()), 32'd0);
    measure_busy(n, g);
    check_output("v1_gap_len", 32'(n), 32'(GAP));
    check_output("v1_gap_gnt", 32'(g), 32'd0);

    $display("[TB] V2 both requesting out of reset");
    rst = 1'b0;
    tick();
    req0 = 1'b1;
    req1 = 1'b1;
    for (int r = 0; r < 2; r++) begin
      payload = '{8'hAA, 8'h55};
      load_frame(0, 4);
      payload = '{8'h12, 8'h34};
      load_frame(1, 4);
    end
    gnt_log.delete();
    d0 = n_done0 + n_done1;
    rst = 1'b1;
    tick();
    check_output("v2_first_gnt", 32'(gnt), 32'h1);
    k = 0;
    while ((n_done0 + n_done1) < d0 + 4 && k < 6000) begin
      tick();
      k++;
    end
    req0 = 1'b0;
    req1 = 1'b0;
    check_output("v2_done_count", 32'(n_done0 + n_done1 - d0), 32'd4);
    check_output("v2_grant_count", 32'(gnt_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < gnt_log.size(); i++)
      check_output($sformatf("v2_grant_%0d", i), 32'(gnt_log[i]), (i % 2 == 0) ? 32'h1 : 32'h2);
    check_output("v2_sb_empty", 32'(exp_q.size()), 32'd0);
    measure_busy(n, g);

    $display("[TB] V3 zero-length frame");
    payload.delete();
    load_frame(0, 0);
    fl = n_flash;
    d0 = n_done0;
    req0 = 1'b1;
    tick();
    check_output("v3_done_in_grant", 32'(done), 32'h1);
    check_output("v3_gnt_in_grant", 32'(gnt), 32'h1);
    req0 = 1'b0;
    tick();
    check_output("v3_done_cleared", 32'(done), 32'd0);
    check_output("v3_gnt_gap", 32'(gnt), 32'd0);
    check_output("v3_busy_gap", 32'(busy), 32'd1);
    measure_busy(n, g);
    check_output("v3_gap_rest", 32'(n), 32'(GAP - 1));
    check_output("v3_no_flash", 32'(n_flash - fl), 32'd0);
    check_output("v3_done_once", 32'(n_done0 - d0), 32'd1);

    $display("[TB] V4 tx_finish timeout after byte 3");
    payload = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    load_frame(0, 3);
    uart_n = 0;
    uart_drop = 3;
    fl = n_flash;
    e = n_err;
    req0 = 1'b1;
    tick();
    req0 = 1'b0;
    wait_flashes(fl + 3, 1000, "v4_three_bytes");
    k = 0;
    while (!err && k < TO + 50) begin
      tick();
      k++;
    end
    check_output("v4_timeout_cycle", 32'(k), 32'(TO));
    check_output("v4_done_with_err", 32'(done), 32'h1);
    measure_busy(n, g);
    check_output("v4_gap_len", 32'(n), 32'(GAP));
    check_output("v4_flashes", 32'(n_flash - fl), 32'd3);
    check_output("v4_err_count", 32'(n_err - e), 32'd1);
    check_output("v4_sb_empty", 32'(exp_q.size()), 32'd0);
    uart_drop = 0;

    $display("[TB] V6 stray tx_finish in IDLE, FETCH, GAP");
    fl = n_flash;
    stray_fin = 1'b1;
    tick();
    stray_fin = 1'b0;
    check_output("v6_idle_busy", 32'(busy), 32'd0);
    payload = '{8'h5A, 8'hA5, 8'h3C};
    load_frame(1, 5);
    req1 = 1'b1;
    tick();
    req1 = 1'b0;
    tick();
    stray_fin = 1'b1;
    tick();
    stray_fin = 1'b0;
    wait_done(1, 2000, "v6_done");
    check_output("v6_flashes", 32'(n_flash - fl), 32'd5);
    check_output("v6_sb_empty", 32'(exp_q.size()), 32'd0);
    tick();
    stray_fin = 1'b1;
    tick();
    stray_fin = 1'b0;
    measure_busy(n, g);
    check_output("v6_gap_len", 32'(n), 32'(GAP - 2));
    check_output("v6_no_gap_flash", 32'(n_flash - fl), 32'd5);

    $display("[TB] V5 reset mid-frame");
    payload = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    load_frame(0, 8);
    fl = n_flash;
    d0 = n_done0;
    d1 = n_done1;
    e = n_err;
    req0 = 1'b1;
    tick();
    req0 = 1'b0;
    wait_flashes(fl + 2, 1000, "v5_two_bytes");
    repeat (30) tick();
    rst = 1'b0;
    #1;
    check_output("v5_rst_gnt", 32'(gnt), 32'd0);
    check_output("v5_rst_done", 32'(done), 32'd0);
    check_output("v5_rst_err", 32'(err), 32'd0);
    check_output("v5_rst_busy", 32'(busy), 32'd0);
    check_output("v5_rst_flash", 32'(data_tx_flash), 32'd0);
    check_output("v5_rst_data_tx", 32'(data_tx), 32'd0);
    check_output("v5_rst_rd_addr", 32'(rd_addr), 32'd0);
    exp_q.delete();
    tick(); tick(); tick();
    rst = 1'b1;
    k = 0;
    while (!uart_fin && k < 2 * UART_LAT) begin
      tick();
      k++;
    end
    check_output("v5_late_finish_seen", 32'(uart_fin), 32'd1);
    tick();
    check_output("v5_late_finish_busy", 32'(busy), 32'd0);
    check_output("v5_no_flash_after_rst", 32'(n_flash - fl), 32'd2);
    check_output("v5_no_done_ch0", 32'(n_done0 - d0), 32'd0);
    check_output("v5_no_err", 32'(n_err - e), 32'd0);
    payload = '{8'h77};
    load_frame(1, 3);
    req1 = 1'b1;
    tick();
    check_output("v5_req1_granted", 32'(gnt), 32'h2);
    req1 = 1'b0;
    wait_done(1, 1000, "v5_ch1_done");
    check_output("v5_ch1_flashes", 32'(n_flash - fl), 32'd5);
    check_output("v5_ch1_done_once", 32'(n_done1 - d1), 32'd1);
    measure_busy(n, g);

    $display("[TB] len 255 boundary");
    payload.delete();
    for (int i = 0; i < 255; i++) payload.push_back(8'($urandom_range(0, 255)));
    load_frame(0, 257);
    fl = n_flash;
    rd_addr_max = 0;
    req0 = 1'b1;
    tick();
    req0 = 1'b0;
    wait_done(0, 30000, "len255_done");
    check_output("len255_flashes", 32'(n_flash - fl), 32'd257);
    check_output("len255_rd_addr_max", 32'(rd_addr_max), 32'd254);
    check_output("len255_sb_empty", 32'(exp_q.size()), 32'd0);
    measure_busy(n, g);
    check_output("len255_gap_len", 32'(n), 32'(GAP));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
